// File: rtl/keypad_pkg.sv
`default_nettype none
//==============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the 4x4 matrix keypad scanner:
//               default timing parameters, FSM state encoding, the key map
//               indexed by {row,col}, and the row-priority helper.
// Revision    : 1.0 - initial release
//==============================================================================
package keypad_pkg;

   // Default timing: 1 ms per column at 100 MHz, four matching samples to
   // accept a press or a release.
   localparam int SCAN_TICKS_DEF       = 100000;
   localparam int DEBOUNCE_SAMPLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   // Key map, element index = {row[1:0], col[1:0]}.
   localparam logic [0:15][3:0] c_key_map = {
      4'h1, 4'h2, 4'h3, 4'hA,   // row 0
      4'h4, 4'h5, 4'h6, 4'hB,   // row 1
      4'h7, 4'h8, 4'h9, 4'hC,   // row 2
      4'h0, 4'hF, 4'hE, 4'hD    // row 3
   };

   // Index of the lowest-numbered row that is low (active). Returns 0 when
   // no row is low; callers qualify with their own "any row low" test.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_row_sync.sv
`default_nettype none
//==============================================================================
// Module      : keypad_row_sync
// Description : Two-flop synchronizer for the four active-low keypad rows.
//               Resets to all-high (no key pressed).
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               i_rows - raw row lines, asynchronous to clk
//               o_rows - synchronized row lines
// Revision    : 1.0 - initial release
//==============================================================================
module keypad_row_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_rows,
   output logic [3:0] o_rows
);

   logic [3:0] r_meta;
   logic [3:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 4'hF;
         r_sync <= 4'hF;
      end else begin
         r_meta <= i_rows;
         r_sync <= r_meta;
      end
   end

   assign o_rows = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
//==============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               samples the synchronized rows once per column window,
//               debounces press and release, and reports the key code with a
//               one-cycle valid strobe.
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               i_rows      - row lines, active-low, asynchronous
//               o_cols      - column drive, active-low, exactly one bit low
//               o_key_code  - code of the last accepted key
//               o_key_valid - one-cycle pulse per accepted press
//               o_key_held  - high from acceptance until release debounced
// Revision    : 1.0 - initial release
//==============================================================================
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS       = SCAN_TICKS_DEF,       // minimum 4
   parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF  // minimum 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i_rows,
   output logic [3:0] o_cols,
   output logic [3:0] o_key_code,
   output logic       o_key_valid,
   output logic       o_key_held
);

   localparam int TICK_W = $clog2(SCAN_TICKS);
   localparam int CNT_W  = $clog2(DEBOUNCE_SAMPLES + 1);

   localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(SCAN_TICKS - 1);
   // Count value that, once one more matching sample arrives, completes
   // the debounce window.
   localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(DEBOUNCE_SAMPLES - 1);

   // Synchronized rows
   logic [3:0] w_rs;

   keypad_row_sync u_row_sync (
      .clk    (clk),
      .rst    (rst),
      .i_rows (i_rows),
      .o_rows (w_rs)
   );

   // Tick counter: free-running over one column window. The column only
   // changes on the sample cycle, so the wrap doubles as the restart.
   logic [TICK_W-1:0] r_tick;
   logic              w_sample;

   assign w_sample = (r_tick == c_tick_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick <= '0;
      end else if (w_sample) begin
         r_tick <= '0;
      end else begin
         r_tick <= r_tick + TICK_W'(1);
      end
   end

   // FSM and datapath registers
   state_t           r_state,  w_state;
   logic [1:0]       r_col,    w_col;
   logic [3:0]       r_cols,   w_cols;
   logic [1:0]       r_row,    w_row;
   logic [CNT_W-1:0] r_cnt,    w_cnt;
   logic [3:0]       r_code,   w_code;
   logic             r_valid,  w_valid;
   logic             r_held,   w_held;

   logic             w_any_low;
   logic [1:0]       w_low_row;
   logic             w_advance;

   assign w_any_low = (w_rs != 4'hF);
   assign w_low_row = lowest_low_row(w_rs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SCAN;
         r_col   <= 2'd0;
         r_cols  <= 4'b1110;
         r_row   <= 2'd0;
         r_cnt   <= '0;
         r_code  <= 4'h0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_col   <= w_col;
         r_cols  <= w_cols;
         r_row   <= w_row;
         r_cnt   <= w_cnt;
         r_code  <= w_code;
         r_valid <= w_valid;
         r_held  <= w_held;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_col     = r_col;
      w_cols    = r_cols;
      w_row     = r_row;
      w_cnt     = r_cnt;
      w_code    = r_code;
      w_valid   = 1'b0;
      w_held    = r_held;
      w_advance = 1'b0;

      if (w_sample) begin
         case (r_state)
            ST_SCAN: begin
               if (!w_any_low) begin
                  w_advance = 1'b1;
               end else begin
                  w_row   = w_low_row;
                  w_cnt   = CNT_W'(1);
                  w_state = ST_DEBOUNCE;
               end
            end

            ST_DEBOUNCE: begin
               // The captured row must still be the winning low row;
               // anything else counts as a bounce and aborts the attempt.
               if (w_any_low && (w_low_row == r_row)) begin
                  if (r_cnt == c_cnt_last) begin
                     w_code  = c_key_map[{r_row, r_col}];
                     w_valid = 1'b1;
                     w_held  = 1'b1;
                     w_cnt   = '0;
                     w_state = ST_HELD;
                  end else begin
                     w_cnt = r_cnt + CNT_W'(1);
                  end
               end else begin
                  w_state   = ST_SCAN;
                  w_advance = 1'b1;
               end
            end

            ST_HELD: begin
               // Only the captured row matters here; other keys on the
               // frozen column are ignored.
               if (w_rs[r_row]) begin
                  if (r_cnt == c_cnt_last) begin
                     w_held    = 1'b0;
                     w_cnt     = '0;
                     w_state   = ST_SCAN;
                     w_advance = 1'b1;
                  end else begin
                     w_cnt = r_cnt + CNT_W'(1);
                  end
               end else begin
                  w_cnt = '0;
               end
            end

            default: begin
               w_state = ST_SCAN;
            end
         endcase
      end

      if (w_advance) begin
         w_col  = r_col + 2'd1;
         w_cols = ~(4'b0001 << w_col);
      end
   end

   assign o_cols      = r_cols;
   assign o_key_code  = r_code;
   assign o_key_valid = r_valid;
   assign o_key_held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
//==============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with SCAN_TICKS=4 and
//               DEBOUNCE_SAMPLES=3. A keypad model pulls a row low only while
//               its column is driven. A behavioural reference model predicts
//               all outputs every cycle; a key table and hand-written
//               sequences cover the individual scenarios.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_keypad_scanner;

   localparam int SCAN_T = 4;
   localparam int DEB    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  code;
   logic        valid;
   logic        held;

   logic [15:0] keys;   // pressed keys, bit index = row*4 + col

   int n_checks = 0;
   int n_errors = 0;
   int n_pulses = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_TICKS       (SCAN_T),
      .DEBOUNCE_SAMPLES (DEB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rows      (rows),
      .o_cols      (cols),
      .o_key_code  (code),
      .o_key_valid (valid),
      .o_key_held  (held)
   );

   // Keypad matrix: a pressed key shorts its row to its column.
   always_comb begin
      rows = 4'hF;
      for (int k = 0; k < 16; k++) begin
         if (keys[k] && !cols[k % 4]) rows[k / 4] = 1'b0;
      end
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (valid === 1'b1) n_pulses++;
   end

   //---------------------------------------------------------------------------
   // Reference model. Works one clock ahead: at each falling edge it checks
   // the present outputs, then applies the scanning rules to the rows the
   // scanner will see at the next rising edge (two cycles late, through the
   // synchronizer history).
   //---------------------------------------------------------------------------
   localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2;

   logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                             '{4'h4, 4'h5, 4'h6, 4'hB},
                             '{4'h7, 4'h8, 4'h9, 4'hC},
                             '{4'h0, 4'hF, 4'hE, 4'hD}};

   int         m_mode, m_col, m_row, m_cnt, m_tick;
   logic [3:0] m_code, m_h0, m_h1;
   logic       m_valid, m_held;

   always @(negedge clk) begin
      logic [3:0] rs_now;
      bit         smp;
      int         lr;
      if (rst === 1'b1) begin
         m_mode = M_SCAN; m_col = 0; m_row = 0; m_cnt = 0; m_tick = 0;
         m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
         m_h0 = 4'hF; m_h1 = 4'hF;
      end
      chk("model_cols",  cols,  4'hF & ~(4'h1 << m_col));
      chk("model_valid", valid, m_valid);
      chk("model_code",  code,  m_code);
      chk("model_held",  held,  m_held);
      if (rst !== 1'b1) begin
         rs_now = m_h1; m_h1 = m_h0; m_h0 = rows;
         smp    = (m_tick == SCAN_T - 1);
         m_tick = (m_tick + 1) % SCAN_T;
         m_valid = 1'b0;
         if (smp) begin
            lr = -1;
            for (int i = 3; i >= 0; i--) if (!rs_now[i]) lr = i;
            case (m_mode)
               M_SCAN: begin
                  if (lr < 0) m_col = (m_col + 1) % 4;
                  else begin m_row = lr; m_cnt = 1; m_mode = M_DEB; end
               end
               M_DEB: begin
                  if (lr == m_row) begin
                     m_cnt++;
                     if (m_cnt == DEB) begin
                        m_code = km[m_row][m_col]; m_valid = 1'b1;
                        m_held = 1'b1; m_mode = M_HELD; m_cnt = 0;
                     end
                  end else begin
                     m_mode = M_SCAN; m_col = (m_col + 1) % 4;
                  end
               end
               default: begin
                  if (rs_now[m_row]) begin
                     m_cnt++;
                     if (m_cnt == DEB) begin
                        m_held = 1'b0; m_mode = M_SCAN;
                        m_col = (m_col + 1) % 4; m_cnt = 0;
                     end
                  end else m_cnt = 0;
               end
            endcase
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers: all stimulus points sit 1 time unit after a rising edge.
   //---------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int limit);
      int n = 0;
      while (valid !== 1'b1 && n < limit) begin step(1); n++; end
      chk("wait_valid", valid, 1'b1);
   endtask

   task automatic wait_released(input int limit);
      int n = 0;
      while (held !== 1'b0 && n < limit) begin step(1); n++; end
      chk("wait_released", held, 1'b0);
   endtask

   task automatic wait_cols(input logic [3:0] want, input int limit);
      int n = 0;
      while (cols !== want && n < limit) begin step(1); n++; end
      chk("wait_cols", cols, want);
   endtask

   function automatic int kidx(input int r, input int c);
      return r * 4 + c;
   endfunction

   typedef struct {
      int         row;
      int         col;
      logic [3:0] exp_code;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int base;
      int kk;
      tbl = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
              '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
              '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
              '{3,0,4'h0}, '{3,1,4'hF}, '{3,2,4'hE}, '{3,3,4'hD}};
      keys = 16'h0;
      rst  = 1'b1;
      step(3);

      // Reset state and idle column rotation
      chk("reset_cols",  cols,  4'b1110);
      chk("reset_code",  code,  4'h0);
      chk("reset_valid", valid, 1'b0);
      chk("reset_held",  held,  1'b0);
      base = n_pulses;
      rst = 1'b0;
      step(2);  chk("idle_col0", cols, 4'b1110);
      step(4);  chk("idle_col1", cols, 4'b1101);
      step(4);  chk("idle_col2", cols, 4'b1011);
      step(4);  chk("idle_col3", cols, 4'b0111);
      step(4);  chk("idle_wrap", cols, 4'b1110);
      chk("idle_no_pulse", n_pulses - base, 0);
      chk("idle_code", code, 4'h0);

      // Key "5": exact latency, one pulse, held until release debounced
      base = n_pulses;
      wait_cols(4'b1110, 20);
      keys[kidx(1,1)] = 1'b1;
      wait_cols(4'b1101, 20);
      step(11); chk("k5_before", valid, 1'b0);
      step(1);  chk("k5_valid", valid, 1'b1);
                chk("k5_code", code, 4'h5);
                chk("k5_held", held, 1'b1);
                chk("k5_frozen", cols, 4'b1101);
      step(1);  chk("k5_pulse_len", valid, 1'b0);
      step(10); chk("k5_still_held", held, 1'b1);
      keys = 16'h0;
      wait_released(60);
      chk("k5_resume", cols, 4'b1011);
      chk("k5_pulses", n_pulses - base, 1);

      // Bounce on "E": one low sample, then high, then steady
      base = n_pulses;
      wait_cols(4'b1110, 30);
      wait_cols(4'b1011, 30);
      keys[kidx(3,2)] = 1'b1;
      step(4);
      keys[kidx(3,2)] = 1'b0;
      step(1);  chk("kE_debounce_frozen", cols, 4'b1011);
      step(3);  chk("kE_abort_advance", cols, 4'b0111);
                chk("kE_abort_no_pulse", n_pulses - base, 0);
      keys[kidx(3,2)] = 1'b1;
      wait_valid(60);
      chk("kE_code", code, 4'hE);
      keys = 16'h0;
      wait_released(60);
      chk("kE_pulses", n_pulses - base, 1);

      // "1" and "4" together: lowest row wins
      base = n_pulses;
      keys[kidx(0,0)] = 1'b1;
      keys[kidx(1,0)] = 1'b1;
      wait_valid(60);
      chk("k14_code", code, 4'h1);
      keys = 16'h0;
      wait_released(60);
      step(20);
      chk("k14_pulses", n_pulses - base, 1);

      // "D" held, "A" pressed during HELD: no rollover
      base = n_pulses;
      keys[kidx(3,3)] = 1'b1;
      wait_valid(60);
      chk("kD_code", code, 4'hD);
      step(2);
      keys[kidx(0,3)] = 1'b1;
      step(20);
      chk("kDA_held", held, 1'b1);
      chk("kDA_code", code, 4'hD);
      chk("kDA_cols", cols, 4'b0111);
      keys = 16'h0;
      wait_released(60);
      step(30);
      chk("kDA_pulses", n_pulses - base, 1);
      chk("kDA_code_after", code, 4'hD);

      // Reset during DEBOUNCE on "9"
      base = n_pulses;
      wait_cols(4'b1110, 30);
      keys[kidx(2,2)] = 1'b1;
      wait_cols(4'b1011, 30);
      step(6);
      chk("k9_debounce_frozen", cols, 4'b1011);
      rst = 1'b1;
      #1;
      chk("k9_rst_cols",  cols,  4'b1110);
      chk("k9_rst_code",  code,  4'h0);
      chk("k9_rst_valid", valid, 1'b0);
      chk("k9_rst_held",  held,  1'b0);
      keys = 16'h0;
      step(3);
      rst = 1'b0;
      step(40);
      chk("k9_no_pulse", n_pulses - base, 0);

      // Every key from the table
      for (int i = 0; i < 16; i++) begin
         keys = 16'h0;
         keys[kidx(tbl[i].row, tbl[i].col)] = 1'b1;
         wait_valid(80);
         chk("table_code", code, tbl[i].exp_code);
         keys = 16'h0;
         wait_released(80);
         step($urandom_range(0, 7));
      end

      // Random presses, bounces, chords and resets against the model
      for (int i = 0; i < 40; i++) begin
         kk = $urandom_range(0, 15);
         keys = 16'h0;
         keys[kk] = 1'b1;
         if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
         step($urandom_range(1, 60));
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            step($urandom_range(1, 3));
            rst = 1'b0;
         end
         keys = 16'h0;
         step($urandom_range(1, 40));
      end
      step(60);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display driver.
- Drives one keypad column low at a time and samples the four row lines (Pmod KYPD, 4x4 matrix).
- Debounces press and release, then reports a 4-bit key code with a one-cycle valid strobe.
- Feeds stopwatch/controller logic as a second user-input source alongside the push buttons.

Parameters:
- SCAN_TICKS, 100000, Clock cycles each column is driven before its rows are sampled; minimum 4.
- DEBOUNCE_SAMPLES, 4, Consecutive matching samples required to accept a press or a release; minimum 2.

Ports:
- Clock  input  1  System clock (100 MHz on board).
- Reset  input  1  Asynchronous, active-high reset.
- Rows  input  4  Keypad row lines, active-low (pulled up), asynchronous to Clock.
- Columns  output  4  Column drive, active-low; exactly one bit is low at all times.
- KeyCode  output  4  Code of the last accepted key; holds until the next accepted press.
- KeyValid  output  1  One-cycle pulse when a debounced press is accepted.
- KeyHeld  output  1  High from acceptance until the release is debounced.

Behaviour:
- Reset (async, active-high) sets Columns=4'b1110 (column 0), KeyCode=0, KeyValid=0, KeyHeld=0, state SCAN, and clears the tick and debounce counters.
- Rows pass through a 2-flop synchronizer before any use. Only synchronized rows (rs) are referenced below.
- Tick counter runs 0..SCAN_TICKS-1 and wraps. A "sample" occurs on the cycle tick==SCAN_TICKS-1, which lets rows settle at least 2 cycles after a column change.
- Key map, indexed [row][col]:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: 0,F,E,D
- Several rows low at once: the lowest-index low row wins.
- State SCAN:
  - At each sample, if rs==4'b1111, advance the column (3 wraps to 0) and restart the tick count.
  - Otherwise capture {row,col}, set the debounce count to 1, go to DEBOUNCE, and keep the column.
- State DEBOUNCE (column frozen):
  - At each sample, if the same row is low, increment the count.
  - When the count reaches DEBOUNCE_SAMPLES: load KeyCode from the map, pulse KeyValid in the next cycle, set KeyHeld=1, go to HELD.
  - If the row differs or is released, return to SCAN and advance the column. No output change.
- State HELD (column frozen):
  - Count consecutive samples in which the captured row is high. Any sample with it low resets the count.
  - After DEBOUNCE_SAMPLES consecutive high samples: KeyHeld=0, go to SCAN, advance the column.
  - A second key pressed in HELD is ignored (no rollover).
- KeyValid is registered and high for exactly one cycle per accepted press. There is no auto-repeat.
- Latency: KeyValid rises 1 cycle after the sample that completes debounce. From the first pressed sample this is (DEBOUNCE_SAMPLES-1)*SCAN_TICKS+1 cycles.
- Reset mid-debounce or mid-HELD: the press is abandoned, no KeyValid is produced, and scanning restarts at column 0.
- All state is held in registers. Columns comes straight from a register (no glitches).

Decomposition:
- Shared package keypad_pkg holds:
  - the 16-entry key map constant, indexed {row,col};
  - the state encoding (SCAN, DEBOUNCE, HELD);
  - default parameter values.
- One sub-module, keypad_row_sync: a 4-bit 2-flop synchronizer with async reset to 4'b1111.
- The FSM, tick counter and debounce counter stay in keypad_scanner.

Test Plan (SCAN_TICKS=4, DEBOUNCE_SAMPLES=3; the keypad model pulls a row low only while its column is driven low):
- Reset and idle, no key pressed → Columns cycles 1110,1101,1011,0111 every 4 cycles; KeyValid never asserts; KeyCode=0.
- Hold key "5" (row1,col1) steady → Columns freezes at 1101; one KeyValid pulse with KeyCode=4'h5 exactly 9 cycles after the first pressed sample; KeyHeld=1 until the release is debounced; scanning then resumes.
- Bounce on "E" (row3,col2): low for 1 sample, high for 1, then steady low → the first attempt aborts with no pulse; a single pulse follows with KeyCode=4'hE.
- Press "1" and "4" together (col0, rows 0 and 1) → KeyCode=4'h1 (lowest row wins); exactly one pulse.
- Hold "D" (row3,col3) while also pressing "A" during HELD → no second KeyValid; KeyCode stays 4'hD; after both keys are released, KeyHeld=0.
- Assert Reset during DEBOUNCE on "9" → outputs return to reset values immediately; Columns=1110; no KeyValid is ever produced for that press.
